// File: rtl/alu_adder_arbiter.sv
// Round-robin front end sharing one pipelined adder between two requesters.
// Tags follow each accepted add through the adder so results return to their originator.
module alu_adder_arbiter #(
  parameter int W   = 16,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req0_cin,
  input  logic         req1_cin,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp0_sum,
  output logic [W-1:0] rsp1_sum,
  output logic         rsp0_cout,
  output logic         rsp1_cout
);

  logic         last_grant;
  logic         grant0;
  logic         grant1;
  logic [LAT:0] tag_valid;
  logic [LAT:0] tag_id;

  // On a tie the requester that did not win last time gets the adder.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (grant0) begin
      add_a   = req0_a;
      add_b   = req0_b;
      add_cin = req0_cin;
    end else if (grant1) begin
      add_a   = req1_a;
      add_b   = req1_b;
      add_cin = req1_cin;
    end
  end

  // The last tag stage lines up with the registered result, so it drives the pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid  <= '0;
      tag_id     <= '0;
      last_grant <= 1'b1;
      rsp0_sum   <= '0;
      rsp1_sum   <= '0;
      rsp0_cout  <= 1'b0;
      rsp1_cout  <= 1'b0;
    end else begin
      tag_valid <= {tag_valid[LAT-1:0], grant0 | grant1};
      tag_id    <= {tag_id[LAT-1:0], grant1};
      if (grant0 || grant1) begin
        last_grant <= grant1;
      end
      if (tag_valid[LAT-1]) begin
        if (tag_id[LAT-1]) begin
          rsp1_sum  <= add_sum;
          rsp1_cout <= add_cout;
        end else begin
          rsp0_sum  <= add_sum;
          rsp0_cout <= add_cout;
        end
      end
    end
  end

  assign rsp0_valid = tag_valid[LAT] & ~tag_id[LAT];
  assign rsp1_valid = tag_valid[LAT] &  tag_id[LAT];

endmodule

// File: tb/tb_alu_adder_arbiter.sv
// Drives one request stream into LAT=1 and LAT=3 instances, each fed by a modelled adder,
// and scores grants, adder operands and responses against a reference queue.
module tb_alu_adder_arbiter;
  localparam int W = 16;

  typedef struct {
    int         due;
    logic       id;
    logic [W:0] res;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         run = 1'b0;
  int           cyc = 0;
  logic         req0_valid, req1_valid, req0_cin, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;

  logic         ready0_l1, ready1_l1, add_cin_l1, add_cout_l1;
  logic [W-1:0] add_a_l1, add_b_l1, add_sum_l1;
  logic         rsp0_valid_l1, rsp1_valid_l1, rsp0_cout_l1, rsp1_cout_l1;
  logic [W-1:0] rsp0_sum_l1, rsp1_sum_l1;

  logic         ready0_l3, ready1_l3, add_cin_l3, add_cout_l3;
  logic [W-1:0] add_a_l3, add_b_l3, add_sum_l3;
  logic         rsp0_valid_l3, rsp1_valid_l3, rsp0_cout_l3, rsp1_cout_l3;
  logic [W-1:0] rsp0_sum_l3, rsp1_sum_l3;

  logic [W:0]   pipe1;
  logic [W:0]   pipe3 [3];

  exp_t         exp_q [2][$];
  logic [W-1:0] model_sum [2][2];
  logic         model_cout [2][2];
  logic         model_last = 1'b1;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_adder_arbiter #(.W(W), .LAT(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(ready0_l1), .req1_ready(ready1_l1),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_cin(req0_cin), .req1_cin(req1_cin),
    .add_a(add_a_l1), .add_b(add_b_l1), .add_cin(add_cin_l1),
    .add_sum(add_sum_l1), .add_cout(add_cout_l1),
    .rsp0_valid(rsp0_valid_l1), .rsp1_valid(rsp1_valid_l1),
    .rsp0_sum(rsp0_sum_l1), .rsp1_sum(rsp1_sum_l1),
    .rsp0_cout(rsp0_cout_l1), .rsp1_cout(rsp1_cout_l1)
  );

  alu_adder_arbiter #(.W(W), .LAT(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(ready0_l3), .req1_ready(ready1_l3),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_cin(req0_cin), .req1_cin(req1_cin),
    .add_a(add_a_l3), .add_b(add_b_l3), .add_cin(add_cin_l3),
    .add_sum(add_sum_l3), .add_cout(add_cout_l3),
    .rsp0_valid(rsp0_valid_l3), .rsp1_valid(rsp1_valid_l3),
    .rsp0_sum(rsp0_sum_l3), .rsp1_sum(rsp1_sum_l3),
    .rsp0_cout(rsp0_cout_l3), .rsp1_cout(rsp1_cout_l3)
  );

  // Shared adders, never reset: stale contents must be ignored by the arbiter.
  always @(posedge clk) begin
    pipe1    <= {1'b0, add_a_l1} + {1'b0, add_b_l1} + {{W{1'b0}}, add_cin_l1};
    pipe3[0] <= {1'b0, add_a_l3} + {1'b0, add_b_l3} + {{W{1'b0}}, add_cin_l3};
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign add_sum_l1  = pipe1[W-1:0];
  assign add_cout_l1 = pipe1[W];
  assign add_sum_l3  = pipe3[2][W-1:0];
  assign add_cout_l3 = pipe3[2][W];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, actual, expected, cyc);
    end
  endtask

  task automatic monitorResponses(input int d, input logic [1:0] v,
                                  input logic [W-1:0] s0, input logic c0,
                                  input logic [W-1:0] s1, input logic c1);
    logic [1:0] ev;
    exp_t       e;
    ev = 2'b00;
    if (exp_q[d].size() > 0 && exp_q[d][0].due == cyc) begin
      e = exp_q[d].pop_front();
      ev[e.id] = 1'b1;
      model_sum[d][e.id]  = e.res[W-1:0];
      model_cout[d][e.id] = e.res[W];
    end
    checkOutput(d == 0 ? "l1_rsp_valid" : "l3_rsp_valid", {62'd0, v}, {62'd0, ev});
    checkOutput(d == 0 ? "l1_rsp0" : "l3_rsp0", {47'd0, c0, s0}, {47'd0, model_cout[d][0], model_sum[d][0]});
    checkOutput(d == 0 ? "l1_rsp1" : "l3_rsp1", {47'd0, c1, s1}, {47'd0, model_cout[d][1], model_sum[d][1]});
  endtask

  // All scoring happens here in a fixed order: responses due now, then this cycle's grant.
  always @(negedge clk) begin
    logic       g0, g1;
    logic [W:0] res;
    exp_t       e;
    if (run) begin
      monitorResponses(0, {rsp1_valid_l1, rsp0_valid_l1}, rsp0_sum_l1, rsp0_cout_l1, rsp1_sum_l1, rsp1_cout_l1);
      monitorResponses(1, {rsp1_valid_l3, rsp0_valid_l3}, rsp0_sum_l3, rsp0_cout_l3, rsp1_sum_l3, rsp1_cout_l3);
      if (reset) begin
        checkOutput("ready_in_reset", {60'd0, ready1_l1, ready0_l1, ready1_l3, ready0_l3}, 64'd0);
        for (int d = 0; d < 2; d++) begin
          exp_q[d].delete();
          for (int r = 0; r < 2; r++) begin
            model_sum[d][r]  = '0;
            model_cout[d][r] = 1'b0;
          end
        end
        model_last = 1'b1;
      end else begin
        g0 = req0_valid && (!req1_valid || model_last);
        g1 = !g0 && req1_valid;
        checkOutput("l1_ready", {62'd0, ready1_l1, ready0_l1}, {62'd0, g1, g0});
        checkOutput("l3_ready", {62'd0, ready1_l3, ready0_l3}, {62'd0, g1, g0});
        if (g0 || g1) begin
          if (g0) begin
            res = {1'b0, req0_a} + {1'b0, req0_b} + {{W{1'b0}}, req0_cin};
            checkOutput("l1_operands", {31'd0, add_cin_l1, add_b_l1, add_a_l1}, {31'd0, req0_cin, req0_b, req0_a});
          end else begin
            res = {1'b0, req1_a} + {1'b0, req1_b} + {{W{1'b0}}, req1_cin};
            checkOutput("l1_operands", {31'd0, add_cin_l1, add_b_l1, add_a_l1}, {31'd0, req1_cin, req1_b, req1_a});
          end
          e.id  = g1;
          e.res = res;
          e.due = cyc + 2;
          exp_q[0].push_back(e);
          e.due = cyc + 4;
          exp_q[1].push_back(e);
          model_last = g1;
        end else begin
          checkOutput("l1_idle_operands", {31'd0, add_cin_l1, add_b_l1, add_a_l1}, 64'd0);
        end
      end
    end
  end

  task automatic applyStimulus(input logic rst,
                               input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                               input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1);
    @(posedge clk);
    #1;
    reset      = rst;
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req0_cin   = c0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    req1_cin   = c1;
  endtask

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) begin
        model_sum[d][r]  = '0;
        model_cout[d][r] = 1'b0;
      end
    @(posedge clk);
    #1 run = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] single request, then LAT=3 boundary add");
    applyStimulus(0, 1, 16'h0003, 16'h0004, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h7FFF, 16'h0001, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] tie after reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 16'hFFFF, 16'h0001, 0, 1, 16'h0001, 16'h0002, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h0001, 16'h0002, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] both requesters held valid");
    for (int i = 0; i < 6; i++)
      applyStimulus(0, 1, 16'h1000 + 16'(i), 16'h0100 * 16'(i), i[0],
                       1, 16'hF000 + 16'(3 * i), 16'h1234, 1);

    $display("[TB] req1 back-to-back");
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 0, 0, 0, 1, 16'(i), 16'h0010, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset mid-flight");
    applyStimulus(0, 1, 16'h0101, 16'h0202, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 16'h0001, 16'h0001, 0, 1, 16'h0002, 16'h0002, 0);
    applyStimulus(0, 1, 16'h0005, 16'h0006, 0, 1, 16'h0007, 16'h0008, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++)
      applyStimulus($urandom_range(0, 24) == 0,
                    1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    checkOutput("l1_drain", 64'(exp_q[0].size()), 64'd0);
    checkOutput("l3_drain", 64'(exp_q[1].size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
